// File: rtl/mil_line_arbiter_pkg.sv
// Shared types and defaults for the MIL-STD-1553 line arbiter.
//   MilLineState            : FSM state encoding, also exported on lineState
//   MIL_QUIET_CLK_DEFAULT   : idle-line cycles before a transmit is granted (2 us @ 100 MHz)
//   MIL_TIMEOUT_CLK_DEFAULT : response window / transmitter start limit (14 us @ 100 MHz)
package milStd1553;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TX_WAIT   = 3'd1,
    TX_ACTIVE = 3'd2,
    RESP_WAIT = 3'd3,
    RESP_RX   = 3'd4
  } MilLineState;

  localparam int MIL_QUIET_CLK_DEFAULT   = 200;
  localparam int MIL_TIMEOUT_CLK_DEFAULT = 1400;

endpackage

// File: rtl/mil_line_arbiter_if.sv
// Line-arbiter bus between the SPI-side command logic / mil receiver+transmitter
// (master side) and the arbiter (slave side).
//   master drives : txRequest, txExpectResponse, txBusy, lineBusy, wordReceived
//                   (+ statClear when MIL_ARB_STATS_EN is defined)
//   slave drives  : rxGrant, txGrant, responseTimeout, txFault, lineState
//                   (+ timeoutCount, wordCount when MIL_ARB_STATS_EN is defined)
interface mil_line_arbiter_if;

  logic       txRequest;
  logic       txExpectResponse;
  logic       txBusy;
  logic       lineBusy;
  logic       wordReceived;
  logic       rxGrant;
  logic       txGrant;
  logic       responseTimeout;
  logic       txFault;
  logic [2:0] lineState;
`ifdef MIL_ARB_STATS_EN
  logic        statClear;
  logic [15:0] timeoutCount;
  logic [15:0] wordCount;
`endif

  modport master (
    output txRequest, txExpectResponse, txBusy, lineBusy, wordReceived,
    input  rxGrant, txGrant, responseTimeout, txFault, lineState
`ifdef MIL_ARB_STATS_EN
    , output statClear
    , input  timeoutCount, wordCount
`endif
  );

  modport slave (
    input  txRequest, txExpectResponse, txBusy, lineBusy, wordReceived,
    output rxGrant, txGrant, responseTimeout, txFault, lineState
`ifdef MIL_ARB_STATS_EN
    , input  statClear
    , output timeoutCount, wordCount
`endif
  );

endinterface

// File: rtl/mil_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, nRst : clock, synchronous active-low reset
//   clr       : clear to 0 (wins over inc)
//   inc       : count up by one, holding at MAX
//   value     : current count
module mil_sat_counter #(
  parameter int WIDTH = 12,
  parameter int MAX   = 4095
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk) begin
    if (!nRst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && (value != WIDTH'(MAX))) begin
      value <= value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mil_line_arbiter.sv
// Arbitrates the shared MIL-STD-1553 line between the Manchester receiver and
// transmitter: grants the transmitter only after a quiet gap, watches for the
// transmitter to start, and times the response window after a command.
//   clk, nRst : 100 MHz clock, synchronous active-low reset
//   bus       : mil_line_arbiter_if.slave (requests/line activity in,
//               grants, fault/timeout pulses and lineState out)
// Optional build macro MIL_ARB_STATS_EN adds statClear/timeoutCount/wordCount.
//
// state     | meaning
// IDLE      | listening, counting quiet cycles, waiting for txRequest
// TX_WAIT   | transmitter granted, waiting for txBusy
// TX_ACTIVE | transmitter driving the line
// RESP_WAIT | listening for a reply inside the response window
// RESP_RX   | reply in progress on the line
module mil_line_arbiter
  import milStd1553::*;
#(
  parameter int QUIET_CLK   = MIL_QUIET_CLK_DEFAULT,
  parameter int TIMEOUT_CLK = MIL_TIMEOUT_CLK_DEFAULT,
  parameter int CNT_W       = 12
) (
  input logic               clk,
  input logic               nRst,
  mil_line_arbiter_if.slave bus
);

  MilLineState      state, state_next;
  logic             expect_q, expect_next;
  logic             tmo_next, flt_next;
  logic             rx_grant_q, tx_grant_q, tmo_q, flt_q;
  logic             rx_grant_next, tx_grant_next;
  logic [CNT_W-1:0] quiet_cnt, window_cnt;
  logic             quiet_clr, window_clr, window_inc;
  logic             quiet_full, window_term;

  // Any return to IDLE restarts the quiet gap, so a transmit after a reply
  // or a fault always waits the full QUIET_CLK.
  assign quiet_clr  = bus.lineBusy || ((state_next == IDLE) && (state != IDLE));
  assign window_clr = (state_next != state);
  assign window_inc = (state == TX_WAIT) || (state == RESP_WAIT);

  assign quiet_full  = (quiet_cnt == CNT_W'(QUIET_CLK));
  assign window_term = (window_cnt == CNT_W'(TIMEOUT_CLK - 1));

  mil_sat_counter #(.WIDTH(CNT_W), .MAX(QUIET_CLK)) u_quiet (
    .clk   (clk),
    .nRst  (nRst),
    .clr   (quiet_clr),
    .inc   (!bus.lineBusy),
    .value (quiet_cnt)
  );

  mil_sat_counter #(.WIDTH(CNT_W), .MAX(TIMEOUT_CLK)) u_window (
    .clk   (clk),
    .nRst  (nRst),
    .clr   (window_clr),
    .inc   (window_inc),
    .value (window_cnt)
  );

  always_comb begin
    state_next  = state;
    expect_next = expect_q;
    tmo_next    = 1'b0;
    flt_next    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.txRequest && quiet_full && !bus.lineBusy) begin
          state_next  = TX_WAIT;
          expect_next = bus.txExpectResponse;
        end
      end
      TX_WAIT: begin
        if (bus.txBusy) begin
          state_next = TX_ACTIVE;
        end else if (window_term) begin
          state_next = IDLE;
          flt_next   = 1'b1;
        end
      end
      TX_ACTIVE: begin
        if (!bus.txBusy) begin
          state_next = expect_q ? RESP_WAIT : IDLE;
        end
      end
      RESP_WAIT: begin
        // Line activity on the terminal cycle still counts as a reply.
        if (bus.lineBusy) begin
          state_next = RESP_RX;
        end else if (window_term) begin
          state_next = IDLE;
          tmo_next   = 1'b1;
        end
      end
      RESP_RX: begin
        if (!bus.lineBusy) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Grants are decoded from the next state so they change on the same edge
  // as lineState.
  assign rx_grant_next = (state_next == IDLE) || (state_next == RESP_WAIT) ||
                         (state_next == RESP_RX);
  assign tx_grant_next = (state_next == TX_WAIT) || (state_next == TX_ACTIVE);

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state      <= IDLE;
      expect_q   <= 1'b0;
      rx_grant_q <= 1'b0;
      tx_grant_q <= 1'b0;
      tmo_q      <= 1'b0;
      flt_q      <= 1'b0;
    end else begin
      state      <= state_next;
      expect_q   <= expect_next;
      rx_grant_q <= rx_grant_next;
      tx_grant_q <= tx_grant_next;
      tmo_q      <= tmo_next;
      flt_q      <= flt_next;
    end
  end

  assign bus.rxGrant         = rx_grant_q;
  assign bus.txGrant         = tx_grant_q;
  assign bus.responseTimeout = tmo_q;
  assign bus.txFault         = flt_q;
  assign bus.lineState       = state;

`ifdef MIL_ARB_STATS_EN
  mil_sat_counter #(.WIDTH(16), .MAX(16'hFFFF)) u_timeout_count (
    .clk   (clk),
    .nRst  (nRst),
    .clr   (bus.statClear),
    .inc   (tmo_q || flt_q),
    .value (bus.timeoutCount)
  );

  mil_sat_counter #(.WIDTH(16), .MAX(16'hFFFF)) u_word_count (
    .clk   (clk),
    .nRst  (nRst),
    .clr   (bus.statClear),
    .inc   (bus.wordReceived),
    .value (bus.wordCount)
  );
`else
  // wordReceived only feeds the statistics counters.
  logic word_unused;
  assign word_unused = bus.wordReceived;
`endif

endmodule

// File: tb/tb_mil_line_arbiter.sv
// Scoreboard bench for mil_line_arbiter: stimulus pushes the expected output
// tuple {lineState, rxGrant, txGrant, responseTimeout, txFault} and the edge
// number at which it must appear; a monitor pops on every output change.
module tb_mil_line_arbiter;
  import milStd1553::*;

  typedef struct {
    int         cyc;
    logic [6:0] v;
  } ev_t;

  logic clk = 1'b0;
  logic nRst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  logic [6:0] prev;
  ev_t  q[$];

  mil_line_arbiter_if bus();

  mil_line_arbiter dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] pk(input logic [2:0] s, input logic rx, input logic tx,
                                    input logic tmo, input logic flt);
    return {s, rx, tx, tmo, flt};
  endfunction

  function automatic logic [6:0] sample();
    return {bus.lineState, bus.rxGrant, bus.txGrant, bus.responseTimeout, bus.txFault};
  endfunction

  task automatic push(input int c, input logic [2:0] s, input logic rx, input logic tx,
                      input logic tmo, input logic flt);
    ev_t e;
    e.cyc = c;
    e.v   = pk(s, rx, tx, tmo, flt);
    q.push_back(e);
  endtask

  task automatic go_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, act, req);
    end
  endtask

  // Grant request raised at edge-count e (quiet counter 0 after e): grant edge e+201.
  task automatic grant(input int e, input bit exp_resp, output int g);
    go_to(e);
    bus.txRequest        = 1'b1;
    bus.txExpectResponse = exp_resp;
    g = e + 201;
    push(g, TX_WAIT, 1'b0, 1'b1, 1'b0, 1'b0);
    go_to(g);
    bus.txRequest        = 1'b0;
    bus.txExpectResponse = 1'b0;
  endtask

  // txBusy high for n sampled edges after grant g; returns edge where it falls.
  task automatic transmit(input int g, input int n, input bit exp_resp, output int f);
    go_to(g);
    bus.txBusy = 1'b1;
    push(g + 1, TX_ACTIVE, 1'b0, 1'b1, 1'b0, 1'b0);
    go_to(g + n);
    bus.txBusy = 1'b0;
    f = g + 1 + n;
    if (exp_resp) push(f, RESP_WAIT, 1'b1, 1'b0, 1'b0, 1'b0);
    else          push(f, IDLE, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    logic [6:0] cur;
    ev_t        e;
    if (mon_en) begin
      cur = sample();
      if (cur !== prev) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cyc=%0d got=%b required=no change", cyc, cur);
        end else begin
          e = q.pop_front();
          if ((e.cyc != cyc) || (e.v !== cur)) begin
            errors++;
            $display("FAIL event cyc=%0d got=%b required cyc=%0d value=%b", cyc, cur, e.cyc, e.v);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int e, g, f;
    nRst                 = 1'b0;
    bus.txRequest        = 1'b0;
    bus.txExpectResponse = 1'b0;
    bus.txBusy           = 1'b0;
    bus.lineBusy         = 1'b0;
    bus.wordReceived     = 1'b0;
`ifdef MIL_ARB_STATS_EN
    bus.statClear        = 1'b0;
`endif
    go_to(3);
    chk("reset_outputs", int'(sample()), int'(pk(IDLE, 1'b0, 1'b0, 1'b0, 1'b0)));
    prev   = sample();
    mon_en = 1'b1;

    // Release with line idle and a request already pending.
    e    = cyc;
    nRst = 1'b1;
    push(e + 1, IDLE, 1'b1, 1'b0, 1'b0, 1'b0);
    grant(e, 1'b0, g);
    transmit(g, 2000, 1'b0, f);

    // Reset in the middle of a transmit drops both grants.
    grant(f, 1'b0, g);
    bus.txBusy = 1'b1;
    push(g + 1, TX_ACTIVE, 1'b0, 1'b1, 1'b0, 1'b0);
    go_to(g + 10);
    nRst       = 1'b0;
    bus.txBusy = 1'b0;
    push(g + 11, IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
    go_to(g + 11);
    nRst = 1'b1;
    push(g + 12, IDLE, 1'b1, 1'b0, 1'b0, 1'b0);
    e = g + 11;

    // Response expected, none arrives.
    grant(e, 1'b1, g);
    transmit(g, 20, 1'b1, f);
    push(f + 1400, IDLE, 1'b1, 1'b0, 1'b1, 1'b0);
    push(f + 1401, IDLE, 1'b1, 1'b0, 1'b0, 1'b0);
    e = f + 1400;

    // Reply starts 1000 cycles into the window and lasts 4000 cycles.
    grant(e, 1'b1, g);
    transmit(g, 20, 1'b1, f);
    go_to(f + 999);
    bus.lineBusy = 1'b1;
    push(f + 1000, RESP_RX, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      go_to(f + 1100 + i * 400);
      bus.wordReceived = 1'b1;
      go_to(f + 1101 + i * 400);
      bus.wordReceived = 1'b0;
    end
    go_to(f + 4999);
    bus.lineBusy = 1'b0;
    push(f + 5000, IDLE, 1'b1, 1'b0, 1'b0, 1'b0);
    e = f + 5000;

    // Grant with no transmitter start; request dropped right after grant.
    grant(e, 1'b0, g);
    push(g + 1400, IDLE, 1'b1, 1'b0, 1'b0, 1'b1);
    push(g + 1401, IDLE, 1'b1, 1'b0, 1'b0, 1'b0);
    e = g + 1400;
    grant(e, 1'b0, g);
    transmit(g, 20, 1'b0, f);
    e = f;

    // Line blip at quiet count 150 restarts the quiet gap.
    go_to(e);
    bus.txRequest = 1'b1;
    go_to(e + 150);
    bus.lineBusy = 1'b1;
    go_to(e + 151);
    bus.lineBusy = 1'b0;
    grant(e + 151, 1'b1, g);

    // Reply arrives exactly on the timeout terminal cycle.
    transmit(g, 20, 1'b1, f);
    go_to(f + 1399);
    bus.lineBusy = 1'b1;
    push(f + 1400, RESP_RX, 1'b1, 1'b0, 1'b0, 1'b0);
    go_to(f + 1409);
    bus.lineBusy = 1'b0;
    push(f + 1410, IDLE, 1'b1, 1'b0, 1'b0, 1'b0);
    e = f + 1410;

    // One more unanswered command.
    grant(e, 1'b1, g);
    transmit(g, 20, 1'b1, f);
    push(f + 1400, IDLE, 1'b1, 1'b0, 1'b1, 1'b0);
    push(f + 1401, IDLE, 1'b1, 1'b0, 1'b0, 1'b0);
    e = f + 1400;

    go_to(e + 10);
    chk("pending_events", q.size(), 0);

`ifdef MIL_ARB_STATS_EN
    chk("timeout_count", int'(bus.timeoutCount), 3);
    chk("word_count", int'(bus.wordCount), 5);
    bus.statClear    = 1'b1;
    bus.wordReceived = 1'b1;
    go_to(cyc + 1);
    bus.statClear    = 1'b0;
    bus.wordReceived = 1'b0;
    go_to(cyc + 1);
    chk("timeout_count_clr", int'(bus.timeoutCount), 0);
    chk("word_count_clr", int'(bus.wordCount), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
